// File: rtl/nl2_new_dbank_scrub_req_q_pkg.sv
// Shared nl2 scrub package: queue entry layout and queue depth legality limits.
package nl2_new_dbank_scrub_req_q_pkg;

    // Entries are stored at the widest supported geometry; narrower instances zero-extend.
    localparam int SCRUB_BNK_W_MAX  = 4;
    localparam int SCRUB_ADDR_W_MAX = 32;

    localparam int SCRUB_DEPTH_MIN = 2;
    localparam int SCRUB_DEPTH_MAX = 8;

    typedef struct packed {
        logic [SCRUB_BNK_W_MAX-1:0]  bnk;
        logic [SCRUB_ADDR_W_MAX-1:0] addr;
    } scrub_entry_t;

    function automatic bit scrub_depth_legal(input int depth);
        return (depth == 2) || (depth == 4) || (depth == 8);
    endfunction

endpackage

// File: rtl/nl2_sat_cnt.sv
// Saturating up-counter with a synchronous clear that overrides the increment.
module nl2_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_a,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/nl2_new_dbank_scrub_req_q.sv
// Deduplicating FIFO of correctable-ECC scrub requests between the dbank read
// path and the scrub controller; full-queue drops are tallied in ovf_cnt.
`ifndef nl2_SRAM_BLOCK_ADDR_SIZE
`define nl2_SRAM_BLOCK_ADDR_SIZE 12
`endif

module nl2_new_dbank_scrub_req_q
    import nl2_new_dbank_scrub_req_q_pkg::*;
#(
    parameter int N_SRAM          = 4,
    parameter int BLOCK_ADDR_SIZE = `nl2_SRAM_BLOCK_ADDR_SIZE,
    parameter int DEPTH           = 4,
    parameter int OVF_CNT_W       = 8
) (
    input  logic                       clk,
    input  logic                       rst_a,
    input  logic                       ecc_sb_err,
    input  logic [N_SRAM-1:0]          ecc_err_bnk,
    input  logic [BLOCK_ADDR_SIZE-1:0] ecc_err_addr,
    output logic                       req_scrub,
    input  logic                       req_ack,
    output logic [N_SRAM-1:0]          req_bnk,
    output logic [BLOCK_ADDR_SIZE-1:0] req_addr,
    output logic [$clog2(DEPTH):0]     q_level,
    output logic                       q_full,
    output logic [OVF_CNT_W-1:0]       ovf_cnt,
    input  logic                       ovf_clr
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam int IW = PW - 1;

    scrub_entry_t         mem_q [DEPTH];
    logic [DEPTH-1:0]     valid_q;
    logic [PW-1:0]        wptr_q;
    logic [PW-1:0]        rptr_q;

    scrub_entry_t         rpt_entry;
    scrub_entry_t         head;
    logic [DEPTH-1:0]     hit;
    logic                 rpt_valid;
    logic                 rpt_dup;
    logic                 pop;
    logic                 push;
    logic                 drop;
    logic [IW-1:0]        wr_idx;
    logic [IW-1:0]        rd_idx;

    assign rpt_valid = ecc_sb_err && (|ecc_err_bnk);

    always_comb begin
        rpt_entry      = '0;
        rpt_entry.bnk  = SCRUB_BNK_W_MAX'(ecc_err_bnk);
        rpt_entry.addr = SCRUB_ADDR_W_MAX'(ecc_err_addr);
    end

    // The head still counts as present in the cycle it is popped, so a
    // repeat report of the entry being acked is absorbed rather than requeued.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dup
            assign hit[gi] = valid_q[gi] && (mem_q[gi] == rpt_entry);
        end
    endgenerate

    assign rpt_dup = |hit;

    assign wr_idx = wptr_q[IW-1:0];
    assign rd_idx = rptr_q[IW-1:0];

    assign q_level   = wptr_q - rptr_q;
    assign q_full    = (q_level == PW'(DEPTH));
    assign req_scrub = (q_level != '0);

    assign pop  = req_scrub && req_ack;
    assign push = rpt_valid && !rpt_dup && (!q_full || pop);
    assign drop = rpt_valid && !rpt_dup && q_full && !pop;

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (pop) begin
                rptr_q          <= rptr_q + 1'b1;
                valid_q[rd_idx] <= 1'b0;
            end
            // On a full push+pop the write slot is the head slot; the set wins.
            if (push) begin
                wptr_q          <= wptr_q + 1'b1;
                valid_q[wr_idx] <= 1'b1;
                mem_q[wr_idx]   <= rpt_entry;
            end
        end
    end

    assign head     = mem_q[rd_idx];
    assign req_bnk  = req_scrub ? head.bnk[N_SRAM-1:0] : '0;
    assign req_addr = req_scrub ? head.addr[BLOCK_ADDR_SIZE-1:0] : '0;

    nl2_sat_cnt #(
        .W (OVF_CNT_W)
    ) u_ovf_cnt (
        .clk   (clk),
        .rst_a (rst_a),
        .clr_i (ovf_clr),
        .inc_i (drop),
        .cnt_o (ovf_cnt)
    );

endmodule

// File: tb/tb_nl2_new_dbank_scrub_req_q.sv
// Directed scenarios plus randomized traffic checked against a queue-based model.
module tb_nl2_new_dbank_scrub_req_q;

    localparam int N_SRAM   = 4;
    localparam int AW       = 8;
    localparam int DEPTH    = 4;
    localparam int OVW      = 2;
    localparam int OVF_MAX  = (1 << OVW) - 1;

    logic            clk;
    logic            rst_a;
    logic            ecc_sb_err;
    logic [3:0]      ecc_err_bnk;
    logic [AW-1:0]   ecc_err_addr;
    logic            req_scrub;
    logic            req_ack;
    logic [3:0]      req_bnk;
    logic [AW-1:0]   req_addr;
    logic [2:0]      q_level;
    logic            q_full;
    logic [OVW-1:0]  ovf_cnt;
    logic            ovf_clr;

    int n_checks;
    int n_errors;

    // Reference model: plain queues of pending {bank, address} plus a drop tally.
    int mq_bnk[$];
    int mq_addr[$];
    int m_ovf;

    nl2_new_dbank_scrub_req_q #(
        .N_SRAM          (N_SRAM),
        .BLOCK_ADDR_SIZE (AW),
        .DEPTH           (DEPTH),
        .OVF_CNT_W       (OVW)
    ) dut (
        .clk          (clk),
        .rst_a        (rst_a),
        .ecc_sb_err   (ecc_sb_err),
        .ecc_err_bnk  (ecc_err_bnk),
        .ecc_err_addr (ecc_err_addr),
        .req_scrub    (req_scrub),
        .req_ack      (req_ack),
        .req_bnk      (req_bnk),
        .req_addr     (req_addr),
        .q_level      (q_level),
        .q_full       (q_full),
        .ovf_cnt      (ovf_cnt),
        .ovf_clr      (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        int sz;
        sz = mq_bnk.size();
        chk({tag, ".scrub"}, 32'(req_scrub), 32'(sz != 0));
        chk({tag, ".bnk"},   32'(req_bnk),   (sz != 0) ? 32'(mq_bnk[0])  : 32'd0);
        chk({tag, ".addr"},  32'(req_addr),  (sz != 0) ? 32'(mq_addr[0]) : 32'd0);
        chk({tag, ".level"}, 32'(q_level),   32'(sz));
        chk({tag, ".full"},  32'(q_full),    32'(sz == DEPTH));
        chk({tag, ".ovf"},   32'(ovf_cnt),   32'(m_ovf));
    endtask

    // Apply one cycle of inputs, advance the model by the rules, check after the edge.
    task automatic step(input string tag, input logic err, input logic [3:0] bnk,
                        input logic [AW-1:0] addr, input logic ack, input logic clr);
        bit valid, dup, pop, acc;
        int b, a;
        ecc_sb_err   = err;
        ecc_err_bnk  = bnk;
        ecc_err_addr = addr;
        req_ack      = ack;
        ovf_clr      = clr;
        b     = int'(bnk);
        a     = int'(addr);
        valid = err && (b != 0);
        dup   = 1'b0;
        foreach (mq_bnk[i]) begin
            if (mq_bnk[i] == b && mq_addr[i] == a) dup = 1'b1;
        end
        pop = ack && (mq_bnk.size() > 0);
        acc = valid && !dup && ((mq_bnk.size() < DEPTH) || pop);
        if (pop) begin
            void'(mq_bnk.pop_front());
            void'(mq_addr.pop_front());
        end
        if (acc) begin
            mq_bnk.push_back(b);
            mq_addr.push_back(a);
        end
        if (clr) m_ovf = 0;
        else if (valid && !dup && !acc && m_ovf < OVF_MAX) m_ovf++;
        @(posedge clk);
        #1;
        $display("step %s err=%0b bnk=%0h addr=%0h ack=%0b clr=%0b -> scrub=%0b head=%0h/%0h lvl=%0d ovf=%0d",
                 tag, err, bnk, addr, ack, clr, req_scrub, req_bnk, req_addr, q_level, ovf_cnt);
        check_model(tag);
    endtask

    task automatic idle(input string tag, input logic ack);
        step(tag, 1'b0, 4'h0, '0, ack, 1'b0);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        m_ovf        = 0;
        rst_a        = 1'b1;
        ecc_sb_err   = 1'b0;
        ecc_err_bnk  = '0;
        ecc_err_addr = '0;
        req_ack      = 1'b0;
        ovf_clr      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_model("reset_held");
        rst_a = 1'b0;
        idle("post_reset", 1'b1);

        // Order: ack tied high, two reports on consecutive cycles.
        step("order_a", 1'b1, 4'b0001, 8'h10, 1'b1, 1'b0);
        chk("order_first_addr", 32'(req_addr), 32'h10);
        step("order_b", 1'b1, 4'b0100, 8'h20, 1'b1, 1'b0);
        chk("order_second_addr", 32'(req_addr), 32'h20);
        idle("order_drain", 1'b1);
        chk("order_empty", 32'(req_scrub), 32'd0);

        // Dedup: same report three times, no ack.
        repeat (3) step("dedup", 1'b1, 4'b0010, 8'h05, 1'b0, 1'b0);
        chk("dedup_level", 32'(q_level), 32'd1);
        chk("dedup_ovf", 32'(ovf_cnt), 32'd0);
        idle("dedup_pop", 1'b1);

        // Zero-bank report is ignored entirely.
        step("zero_bnk", 1'b1, 4'b0000, 8'h33, 1'b0, 1'b0);
        chk("zero_bnk_level", 32'(q_level), 32'd0);

        // Overflow: six distinct reports into a four-deep queue.
        for (int i = 0; i < 6; i++) begin
            step("ovf_fill", 1'b1, 4'b1000, AW'(8'h40 + i), 1'b0, 1'b0);
        end
        chk("ovf_full", 32'(q_full), 32'd1);
        chk("ovf_cnt2", 32'(ovf_cnt), 32'd2);
        chk("ovf_head", 32'(req_addr), 32'h40);

        // Full with simultaneous push and pop.
        step("full_pushpop", 1'b1, 4'b0001, 8'h77, 1'b1, 1'b0);
        chk("full_pushpop_level", 32'(q_level), 32'd4);
        chk("full_pushpop_ovf", 32'(ovf_cnt), 32'd2);
        chk("full_pushpop_head", 32'(req_addr), 32'h41);

        // Saturation then clear-over-increment.
        for (int i = 0; i < 5; i++) begin
            step("sat_drop", 1'b1, 4'b0100, AW'(8'h90 + i), 1'b0, 1'b0);
        end
        chk("sat_cnt", 32'(ovf_cnt), 32'd3);
        step("clr_drop", 1'b1, 4'b0100, 8'hA0, 1'b0, 1'b1);
        chk("clr_wins", 32'(ovf_cnt), 32'd0);

        // Reset mid-operation with three entries pending.
        idle("pre_rst_pop", 1'b1);
        chk("pre_rst_level", 32'(q_level), 32'd3);
        ecc_sb_err = 1'b0;
        req_ack    = 1'b0;
        #2;
        rst_a = 1'b1;
        #1;
        mq_bnk.delete();
        mq_addr.delete();
        m_ovf = 0;
        chk("rst_async_scrub", 32'(req_scrub), 32'd0);
        chk("rst_async_level", 32'(q_level), 32'd0);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        repeat (3) idle("after_rst", 1'b0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [3:0] rb;
            logic       re, ra, rc;
            case ($urandom_range(0, 4))
                0: rb = 4'b0000;
                1: rb = 4'b0001;
                2: rb = 4'b0010;
                3: rb = 4'b0100;
                default: rb = 4'b1000;
            endcase
            re = ($urandom_range(0, 9) < 7);
            ra = ($urandom_range(0, 9) < 3);
            rc = ($urandom_range(0, 19) == 0);
            step("rand", re, rb, AW'($urandom_range(0, 5)), ra, rc);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
